// File: rtl/seg_display_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_display_scan_pkg
// Desc    : Register map, CTRL fields, scan state encoding and hex segment table
// Rev     : 1.0 - initial release
// ============================================================================
package seg_display_scan_pkg;

    localparam logic [7:0] c_reg_value    = 8'd0;
    localparam logic [7:0] c_reg_ctrl     = 8'd1;
    localparam logic [7:0] c_reg_prescale = 8'd2;
    localparam logic [7:0] c_reg_status   = 8'd3;

    localparam int c_ctrl_en_bit    = 0;
    localparam int c_ctrl_blank_lsb = 8;
    localparam int c_ctrl_dp_lsb    = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    // Active-low segment patterns {dp,g..a}; dp held off, entry 15 first.
    localparam logic [15:0][7:0] c_seg_table = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage
`default_nettype wire

// File: rtl/seg_display_scan_if.sv
`default_nettype none
// ============================================================================
// Module  : seg_display_scan_if
// Desc    : Peripheral register bus (byte-enable write, registered read)
// Rev     : 1.0 - initial release
// ============================================================================
interface seg_display_scan_if;

    logic [7:0]  addrIn;
    logic [7:0]  addrOut;
    logic [3:0]  sizeDecode;
    logic [31:0] dataIn;
    logic [31:0] dataOut;

    modport master (
        output addrIn,
        output addrOut,
        output sizeDecode,
        output dataIn,
        input  dataOut
    );

    modport slave (
        input  addrIn,
        input  addrOut,
        input  sizeDecode,
        input  dataIn,
        output dataOut
    );

endinterface
`default_nettype wire

// File: rtl/seg_display_scan_seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module  : seg7_hex_decoder
// Desc    : Combinational hex nibble to active-low 7-segment {g..a} pattern
// Rev     : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import seg_display_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = c_seg_table[i_nibble][6:0];

endmodule
`default_nettype wire

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module  : seg_display_scan
// Desc    : Memory-mapped multiplexed 8-digit seven-segment display scanner
// Rev     : 1.0 - initial release
// ============================================================================
module seg_display_scan
    import seg_display_scan_pkg::*;
#(
    parameter int          NUM_DIGITS       = 8,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd50000,
    parameter int          BLANK_CYCLES     = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    seg_display_scan_if.slave     bus,
    output logic [NUM_DIGITS-1:0] DIG,
    output logic [7:0]            SEG
);

    localparam logic [15:0] c_blank_last = 16'(BLANK_CYCLES - 1);
    localparam logic [2:0]  c_last_idx   = 3'(NUM_DIGITS - 1);

    logic [31:0]           r_value;
    logic [31:0]           r_ctrl;
    logic [15:0]           r_prescale;
    logic [31:0]           r_rdata;
    scan_state_t           r_state;
    logic [2:0]            r_idx;
    logic [15:0]           r_cnt;
    logic [15:0]           r_pre_l;
    logic [15:0]           r_frame;
    logic [NUM_DIGITS-1:0] r_dig;
    logic [7:0]            r_seg;

    logic                  w_en;
    logic [7:0]            w_blankmask;
    logic [7:0]            w_dpmask;
    logic [3:0]            w_nibble;
    logic [6:0]            w_dec;
    logic [NUM_DIGITS-1:0] w_dig_show;
    logic [7:0]            w_seg_show;
    logic [31:0]           w_rdata;

    assign w_en        = r_ctrl[c_ctrl_en_bit];
    assign w_blankmask = r_ctrl[c_ctrl_blank_lsb +: 8];
    assign w_dpmask    = r_ctrl[c_ctrl_dp_lsb +: 8];
    assign w_nibble    = r_value[{r_idx, 2'b00} +: 4];
    assign w_dig_show  = ~(NUM_DIGITS'(1) << r_idx);
    assign w_seg_show  = w_blankmask[r_idx] ? 8'hFF : {~w_dpmask[r_idx], w_dec};

    seg7_hex_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec)
    );

    // Register writes
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_value    <= 32'd0;
            r_ctrl     <= 32'd0;
            r_prescale <= DEFAULT_PRESCALE;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.sizeDecode[b]) begin
                    if (bus.addrIn == c_reg_value)
                        r_value[8*b +: 8] <= bus.dataIn[8*b +: 8];
                    if (bus.addrIn == c_reg_ctrl)
                        r_ctrl[8*b +: 8] <= bus.dataIn[8*b +: 8];
                end
            end
            if (bus.addrIn == c_reg_prescale) begin
                if (bus.sizeDecode[0]) r_prescale[7:0]  <= bus.dataIn[7:0];
                if (bus.sizeDecode[1]) r_prescale[15:8] <= bus.dataIn[15:8];
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (bus.addrOut)
            c_reg_value:    w_rdata = r_value;
            c_reg_ctrl:     w_rdata = r_ctrl;
            c_reg_prescale: w_rdata = {16'd0, r_prescale};
            c_reg_status:   w_rdata = {r_frame, 11'd0, r_state, r_idx};
            default:        w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_rdata <= 32'd0;
        else       r_rdata <= w_rdata;
    end

    // Scan FSM; outputs are registered from the current state/idx, so they
    // trail the state by one clock except on disable, which blanks at once.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 16'd0;
            r_pre_l <= 16'd0;
            r_frame <= 16'd0;
            r_dig   <= '1;
            r_seg   <= 8'hFF;
        end else if (!w_en) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 16'd0;
            r_dig   <= '1;
            r_seg   <= 8'hFF;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_BLANK;
                    r_cnt   <= 16'd0;
                end
                ST_BLANK: begin
                    if (r_cnt == c_blank_last) begin
                        r_state <= ST_SHOW;
                        r_cnt   <= 16'd0;
                        r_pre_l <= r_prescale;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == r_pre_l) begin
                        r_state <= ST_BLANK;
                        r_cnt   <= 16'd0;
                        if (r_idx == c_last_idx) begin
                            r_idx   <= 3'd0;
                            r_frame <= r_frame + 16'd1;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 16'd0;
                end
            endcase

            if (r_state == ST_SHOW) begin
                r_dig <= w_dig_show;
                r_seg <= w_seg_show;
            end else begin
                r_dig <= '1;
                r_seg <= 8'hFF;
            end
        end
    end

    assign bus.dataOut = r_rdata;
    assign DIG         = r_dig;
    assign SEG         = r_seg;

endmodule
`default_nettype wire
